// File: rtl/morse_stream_decoder_if.sv
// Symbol-in / character-out bundle for morse_stream_decoder.
// Both sides use valid/ready: a transfer happens on a rising clk edge where valid and ready are both high.
interface morse_stream_decoder_if #(
   parameter int FIFO_DEPTH = 4
);
   logic                          sym_valid;
   logic [1:0]                    sym_type;
   logic                          sym_ready;
   logic [7:0]                    ascii_data;
   logic                          ascii_valid;
   logic                          ascii_ready;
   logic                          err;
   logic [$clog2(FIFO_DEPTH):0]   fifo_count;

   // master: symbol source and character sink. slave: the decoder.
   modport master (
      output sym_valid, sym_type, ascii_ready,
      input  sym_ready, ascii_data, ascii_valid, err, fifo_count
   );

   modport slave (
      input  sym_valid, sym_type, ascii_ready,
      output sym_ready, ascii_data, ascii_valid, err, fifo_count
   );
endinterface

// File: rtl/morse_stream_decoder.sv
// Collects Morse dots/dashes into a code word, decodes it to ASCII and queues the result in a small FIFO.
// Define MORSE_DIGITS_EN to also decode the five-symbol digits 0-9.
module morse_stream_decoder #(
   parameter int MAX_SYMBOLS = 5,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   morse_stream_decoder_if.slave bus,
   output logic [1:0]            fsm_state
);
   localparam int CW = 2 * MAX_SYMBOLS;
   localparam int NW = $clog2(MAX_SYMBOLS + 1);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] DEPTH = (AW + 1)'(FIFO_DEPTH);

   localparam logic [1:0] SYM_WORD_END = 2'b00;
   localparam logic [1:0] DOT = 2'b10;
   localparam logic [1:0] DSH = 2'b11;
   localparam logic [1:0] NIL = 2'b00;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      LOOKUP  = 2'd2,
      SPACE   = 2'd3
   } state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  code_q;
   logic [NW-1:0]  cnt_q;
   logic           overrun_q;
   logic           last_space_q;
   logic           pend_space_q;
   logic           err_q;

   logic [7:0]     mem [FIFO_DEPTH];
   logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [AW:0]    count_q;

   logic           sym_ready_c;
   logic           accept;
   logic           full, empty, pop, push;
   logic [7:0]     push_data;
   logic           store_sym, set_overrun, load_pend, clear_code, lookup_err;
   logic           dec_valid;
   logic [7:0]     dec_char;
   logic [CW-1:0]  sym_slot;

   // Only the top five slots can hold a legal code; longer codes are rejected by the slot count.
   function automatic logic [8:0] decode(input logic [9:0] c);
      logic [8:0] r;
      r = 9'h000;
      case (c)
         {DOT, DSH, NIL, NIL, NIL}: r = {1'b1, 8'h41};
         {DSH, DOT, DOT, DOT, NIL}: r = {1'b1, 8'h42};
         {DSH, DOT, DSH, DOT, NIL}: r = {1'b1, 8'h43};
         {DSH, DOT, DOT, NIL, NIL}: r = {1'b1, 8'h44};
         {DOT, NIL, NIL, NIL, NIL}: r = {1'b1, 8'h45};
         {DOT, DOT, DSH, DOT, NIL}: r = {1'b1, 8'h46};
         {DSH, DSH, DOT, NIL, NIL}: r = {1'b1, 8'h47};
         {DOT, DOT, DOT, DOT, NIL}: r = {1'b1, 8'h48};
         {DOT, DOT, NIL, NIL, NIL}: r = {1'b1, 8'h49};
         {DOT, DSH, DSH, DSH, NIL}: r = {1'b1, 8'h4A};
         {DSH, DOT, DSH, NIL, NIL}: r = {1'b1, 8'h4B};
         {DOT, DSH, DOT, DOT, NIL}: r = {1'b1, 8'h4C};
         {DSH, DSH, NIL, NIL, NIL}: r = {1'b1, 8'h4D};
         {DSH, DOT, NIL, NIL, NIL}: r = {1'b1, 8'h4E};
         {DSH, DSH, DSH, NIL, NIL}: r = {1'b1, 8'h4F};
         {DOT, DSH, DSH, DOT, NIL}: r = {1'b1, 8'h50};
         {DSH, DSH, DOT, DSH, NIL}: r = {1'b1, 8'h51};
         {DOT, DSH, DOT, NIL, NIL}: r = {1'b1, 8'h52};
         {DOT, DOT, DOT, NIL, NIL}: r = {1'b1, 8'h53};
         {DSH, NIL, NIL, NIL, NIL}: r = {1'b1, 8'h54};
         {DOT, DOT, DSH, NIL, NIL}: r = {1'b1, 8'h55};
         {DOT, DOT, DOT, DSH, NIL}: r = {1'b1, 8'h56};
         {DOT, DSH, DSH, NIL, NIL}: r = {1'b1, 8'h57};
         {DSH, DOT, DOT, DSH, NIL}: r = {1'b1, 8'h58};
         {DSH, DOT, DSH, DSH, NIL}: r = {1'b1, 8'h59};
         {DSH, DSH, DOT, DOT, NIL}: r = {1'b1, 8'h5A};
`ifdef MORSE_DIGITS_EN
         {DSH, DSH, DSH, DSH, DSH}: r = {1'b1, 8'h30};
         {DOT, DSH, DSH, DSH, DSH}: r = {1'b1, 8'h31};
         {DOT, DOT, DSH, DSH, DSH}: r = {1'b1, 8'h32};
         {DOT, DOT, DOT, DSH, DSH}: r = {1'b1, 8'h33};
         {DOT, DOT, DOT, DOT, DSH}: r = {1'b1, 8'h34};
         {DOT, DOT, DOT, DOT, DOT}: r = {1'b1, 8'h35};
         {DSH, DOT, DOT, DOT, DOT}: r = {1'b1, 8'h36};
         {DSH, DSH, DOT, DOT, DOT}: r = {1'b1, 8'h37};
         {DSH, DSH, DSH, DOT, DOT}: r = {1'b1, 8'h38};
         {DSH, DSH, DSH, DSH, DOT}: r = {1'b1, 8'h39};
`endif
         default: r = 9'h000;
      endcase
      return r;
   endfunction

   logic [8:0] dec_word;
   assign dec_word  = decode(code_q[CW-1 -: 10]);
   assign dec_valid = dec_word[8] && (cnt_q <= NW'(5));
   assign dec_char  = dec_word[7:0];

   // New symbol lands in the slot just below the ones already filled.
   assign sym_slot = {bus.sym_type, {(CW-2){1'b0}}} >> {cnt_q, 1'b0};

   assign full  = (count_q == DEPTH);
   assign empty = (count_q == '0);
   assign pop   = !empty && bus.ascii_ready;

   always_comb begin
      state_d     = state_q;
      sym_ready_c = (state_q == IDLE) || (state_q == COLLECT);
      accept      = bus.sym_valid && sym_ready_c;
      store_sym   = 1'b0;
      set_overrun = 1'b0;
      load_pend   = 1'b0;
      clear_code  = 1'b0;
      lookup_err  = 1'b0;
      push        = 1'b0;
      push_data   = 8'h00;

      case (state_q)
         IDLE: begin
            if (accept) begin
               if (bus.sym_type[1]) begin
                  store_sym = 1'b1;
                  state_d   = COLLECT;
               end else if (bus.sym_type == SYM_WORD_END && !last_space_q) begin
                  state_d = SPACE;
               end
            end
         end
         COLLECT: begin
            if (accept) begin
               if (bus.sym_type[1]) begin
                  if (cnt_q < NW'(MAX_SYMBOLS)) store_sym = 1'b1;
                  else                          set_overrun = 1'b1;
               end else begin
                  load_pend = 1'b1;
                  state_d   = LOOKUP;
               end
            end
         end
         LOOKUP: begin
            if (!full || pop) begin
               clear_code = 1'b1;
               if (dec_valid && !overrun_q) begin
                  push      = 1'b1;
                  push_data = dec_char;
               end else begin
                  lookup_err = 1'b1;
               end
               state_d = pend_space_q ? SPACE : IDLE;
            end
         end
         SPACE: begin
            // A rejected letter between two word ends must not produce a second space.
            if (last_space_q) begin
               state_d = IDLE;
            end else if (!full || pop) begin
               push      = 1'b1;
               push_data = 8'h20;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         code_q       <= '0;
         cnt_q        <= '0;
         overrun_q    <= 1'b0;
         last_space_q <= 1'b0;
         pend_space_q <= 1'b0;
         err_q        <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
      end else begin
         state_q <= state_d;
         err_q   <= lookup_err;
         if (clear_code) begin
            code_q    <= '0;
            cnt_q     <= '0;
            overrun_q <= 1'b0;
         end else begin
            if (store_sym) begin
               code_q <= code_q | sym_slot;
               cnt_q  <= cnt_q + 1'b1;
            end
            if (set_overrun) overrun_q <= 1'b1;
         end
         if (load_pend) pend_space_q <= (bus.sym_type == SYM_WORD_END);
         if (push) begin
            wr_ptr_q     <= wr_ptr_q + 1'b1;
            last_space_q <= (push_data == 8'h20);
         end
         if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push && !rst) mem[wr_ptr_q] <= push_data;
   end

   assign bus.sym_ready   = sym_ready_c;
   assign bus.ascii_valid = !empty;
   assign bus.ascii_data  = empty ? 8'h00 : mem[rd_ptr_q];
   assign bus.err         = err_q;
   assign bus.fifo_count  = count_q;
   assign fsm_state       = state_q;
endmodule

// File: tb/tb_morse_stream_decoder.sv
// Bench for morse_stream_decoder: directed corner cases, then random characters checked
// against a pattern-string Morse model and an expected-character queue.
module tb_morse_stream_decoder;
   localparam int MAX_SYMBOLS = 5;
   localparam int FIFO_DEPTH  = 4;
   localparam logic [1:0] T_DOT = 2'b10, T_DASH = 2'b11, T_LETTER = 2'b01, T_WORD = 2'b00;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] fsm_state;

   morse_stream_decoder_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus ();

   morse_stream_decoder #(
      .MAX_SYMBOLS (MAX_SYMBOLS),
      .FIFO_DEPTH  (FIFO_DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .fsm_state (fsm_state)
   );

   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [7:0] exp_q[$];
   int         err_seen = 0;
   int         err_exp  = 0;
   bit         last_sp  = 1'b0;
   bit         rand_ready = 1'b0;
   logic [7:0] morse_map[string];
   string      keys[$];

   string letters[26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
                          "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
                          "..-", "...-", ".--", "-..-", "-.--", "--.."};
   string digits[10]  = '{"-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...",
                          "---..", "----."};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference: whole characters as dot/dash strings looked up in a table.
   function automatic void model_char(input string pat, input bit word);
      if (pat.len() > 0) begin
         if (pat.len() <= MAX_SYMBOLS && morse_map.exists(pat)) begin
            exp_q.push_back(morse_map[pat]);
            last_sp = 1'b0;
         end else begin
            err_exp++;
         end
      end
      if (word && !last_sp) begin
         exp_q.push_back(8'h20);
         last_sp = 1'b1;
      end
   endfunction

   // Called at a negedge; returns at the negedge after the transfer edge.
   task automatic send_sym(input logic [1:0] t);
      int n = 0;
      bus.sym_valid = 1'b1;
      bus.sym_type  = t;
      while (!bus.sym_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("sym_ready_wait", bus.sym_ready, 1);
      @(negedge clk);
      bus.sym_valid = 1'b0;
   endtask

   task automatic send_char(input string pat, input bit word);
      for (int i = 0; i < pat.len(); i++) send_sym((pat[i] == 8'h2E) ? T_DOT : T_DASH);
      model_char(pat, word);
      send_sym(word ? T_WORD : T_LETTER);
   endtask

   task automatic drain();
      int n = 0;
      rand_ready = 1'b0;
      bus.ascii_ready = 1'b1;
      while ((exp_q.size() != 0 || bus.fifo_count != 0 || fsm_state != 2'd0) && n < 400) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      check("drain_fifo", bus.fifo_count, 0);
      check("drain_model", exp_q.size(), 0);
   endtask

   // Scoreboard: pops, hold-while-stalled and err pulses, sampled after inputs settle.
   initial begin : sink
      logic [7:0] held;
      bit         stalled;
      stalled = 1'b0;
      held    = 8'h00;
      forever begin
         @(negedge clk);
         #1;
         if (rst) begin
            stalled = 1'b0;
         end else begin
            if (rand_ready) bus.ascii_ready = 1'($urandom_range(0, 1));
            if (bus.err) err_seen++;
            if (stalled && bus.ascii_valid) check("hold_data", bus.ascii_data, held);
            stalled = bus.ascii_valid && !bus.ascii_ready;
            held    = bus.ascii_data;
            if (bus.ascii_valid && bus.ascii_ready) begin
               check("model_has_char", (exp_q.size() != 0), 1);
               if (exp_q.size() != 0) check("pop_data", bus.ascii_data, exp_q.pop_front());
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin : main
      int e0;
      for (int i = 0; i < 26; i++) morse_map[letters[i]] = 8'h41 + 8'(i);
`ifdef MORSE_DIGITS_EN
      for (int i = 0; i < 10; i++) morse_map[digits[i]] = 8'h30 + 8'(i);
`endif
      foreach (morse_map[k]) keys.push_back(k);

      bus.sym_valid   = 1'b0;
      bus.sym_type    = 2'b00;
      bus.ascii_ready = 1'b0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_count", bus.fifo_count, 0);
      check("rst_valid", bus.ascii_valid, 0);
      check("rst_err", bus.err, 0);
      check("rst_data", bus.ascii_data, 8'h00);
      rst = 1'b0;
      @(negedge clk);
      check("rst_sym_ready", bus.sym_ready, 1);

      // Latency: 'A' visible two cycles after the letter end is accepted.
      bus.ascii_ready = 1'b1;
      send_char(".-", 1'b0);
      check("lat_n1_valid", bus.ascii_valid, 0);
      @(negedge clk);
      check("lat_valid", bus.ascii_valid, 1);
      check("lat_data", bus.ascii_data, 8'h41);
      check("lat_err", bus.err, 0);
      drain();

      // Repeated word end gives a single space.
      bus.ascii_ready = 1'b0;
      send_char(".", 1'b1);
      send_char("", 1'b1);
      repeat (4) @(negedge clk);
      check("word_count", bus.fifo_count, 2);
      check("word_head", bus.ascii_data, 8'h45);
      drain();

      // Overrun: six dots.
      bus.ascii_ready = 1'b0;
      e0 = err_seen;
      send_char("......", 1'b0);
      repeat (3) @(negedge clk);
      check("ovr_err_pulses", err_seen - e0, 1);
      check("ovr_count", bus.fifo_count, 0);
      drain();

      // Digit one.
      bus.ascii_ready = 1'b0;
      e0 = err_seen;
      send_char(".----", 1'b0);
      repeat (3) @(negedge clk);
`ifdef MORSE_DIGITS_EN
      check("digit_count", bus.fifo_count, 1);
      check("digit_head", bus.ascii_data, 8'h31);
      check("digit_err", err_seen - e0, 0);
`else
      check("digit_count", bus.fifo_count, 0);
      check("digit_err", err_seen - e0, 1);
`endif
      drain();

      // Full FIFO stalls LOOKUP; one pop lets the fifth 'T' in on the same edge.
      bus.ascii_ready = 1'b0;
      repeat (5) send_char("-", 1'b0);
      repeat (2) @(negedge clk);
      check("full_count", bus.fifo_count, 4);
      check("full_sym_ready", bus.sym_ready, 0);
      check("full_state", fsm_state, 2'd2);
      bus.ascii_ready = 1'b1;
      @(negedge clk);
      bus.ascii_ready = 1'b0;
      check("poppush_count", bus.fifo_count, 4);
      check("poppush_state", fsm_state, 2'd0);
      drain();

      // Reset right after a dash: the dash is forgotten.
      send_sym(T_DASH);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      last_sp = 1'b0;
      check("mid_rst_count", bus.fifo_count, 0);
      check("mid_rst_valid", bus.ascii_valid, 0);
      check("mid_rst_sym_ready", bus.sym_ready, 1);
      check("mid_rst_data", bus.ascii_data, 8'h00);
      bus.ascii_ready = 1'b1;
      send_char(".", 1'b0);
      drain();

      // Random traffic with random sink back-pressure.
      rand_ready = 1'b1;
      repeat (200) begin
         string pat;
         int    r;
         bit    word;
         r    = $urandom_range(0, 9);
         word = ($urandom_range(0, 4) == 0);
         pat  = "";
         if (r < 6) begin
            pat = keys[$urandom_range(0, keys.size() - 1)];
         end else if (r < 8) begin
            int len;
            len = $urandom_range(1, 7);
            for (int j = 0; j < len; j++) pat = {pat, ($urandom_range(0, 1) != 0) ? "-" : "."};
         end
         send_char(pat, word);
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      drain();
      repeat (3) @(negedge clk);
      check("err_count", err_seen, err_exp);
      check("model_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
